// File: rtl/exc_irq_ctrl.sv
// -----------------------------------------------------------------------------
// exc_irq_ctrl
// Interrupt / exception controller for the single-cycle CPU. It issues PC
// redirect requests to the next-PC selector, produces the return address to
// be written into $26 ($k0), tracks user/kernel mode and holds one pending
// timer interrupt.
//
// Optional feature macro: IRQ_SYNC_EN
//   defined   : irq_in passes a 2-flop synchronizer before the edge-detect flop
//               (pending is set on the 3rd clk edge after irq_in rises)
//   undefined : the edge-detect flop samples irq_in directly
//               (pending is set on the 1st clk edge after irq_in rises)
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   irq_in       in   level interrupt from timer peripheral
//   illop_in     in   undefined opcode flag for current instruction
//   instr_valid  in   current instruction commits this cycle
//   eret_in      in   current instruction is jr $26
//   pc_cur       in   PC of current instruction
//   pc_plus4     in   pc_cur + 4
//   pcsrc_req    out  0 = no redirect, CODE_INT / CODE_EXC = force vector
//   epc          out  return address to write into $26
//   epc_we       out  write strobe for $26
//   kernel       out  1 while in handler
//   irq_pending  out  latched, untaken interrupt
//   nested_fault out  sticky: illegal opcode seen while in kernel
// -----------------------------------------------------------------------------
module exc_irq_ctrl #(
   parameter int unsigned PC_W     = 32,
   parameter logic [2:0]  CODE_INT = 3'd4,
   parameter logic [2:0]  CODE_EXC = 3'd5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            irq_in,
   input  logic            illop_in,
   input  logic            instr_valid,
   input  logic            eret_in,
   input  logic [PC_W-1:0] pc_cur,
   input  logic [PC_W-1:0] pc_plus4,
   output logic [2:0]      pcsrc_req,
   output logic [PC_W-1:0] epc,
   output logic            epc_we,
   output logic            kernel,
   output logic            irq_pending,
   output logic            nested_fault
);

   typedef enum logic {
      ST_USER   = 1'b0,
      ST_KERNEL = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic              pend_q, pend_d;
   logic              nested_q, nested_d;
   logic [PC_W-1:0]   epc_q, epc_d;
   logic              irq_prev_q;
   logic              irq_s;
   logic              irq_rise;
   logic              in_user;
   logic              take_exc;
   logic              take_int;
   logic              do_eret;

`ifdef IRQ_SYNC_EN
   logic sync1_q, sync2_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= irq_in;
         sync2_q <= sync1_q;
      end
   end

   assign irq_s = sync2_q;
`else
   assign irq_s = irq_in;
`endif

   assign irq_rise = irq_s & ~irq_prev_q;
   assign in_user  = (state_q == ST_USER);

   // Mealy decisions; gated by reset so no redirect leaks out while held in reset.
   assign take_exc = reset & instr_valid & in_user & illop_in;
   assign take_int = reset & instr_valid & in_user & ~illop_in & pend_q;
   assign do_eret  = instr_valid & ~in_user & eret_in;

   always_comb begin
      state_d  = state_q;
      epc_d    = epc_q;
      nested_d = nested_q;
      if (take_exc) begin
         state_d = ST_KERNEL;
         epc_d   = pc_plus4;      // faulting instruction is skipped
      end else if (take_int) begin
         state_d = ST_KERNEL;
         epc_d   = pc_cur;        // squashed instruction re-executes on return
      end else if (do_eret) begin
         state_d = ST_USER;
      end
      if (instr_valid && !in_user && illop_in) begin
         nested_d = 1'b1;
      end
   end

   // A new edge in the cycle the interrupt is taken re-arms pending.
   assign pend_d = irq_rise | (pend_q & ~take_int);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_USER;
         pend_q     <= 1'b0;
         nested_q   <= 1'b0;
         epc_q      <= '0;
         irq_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         nested_q   <= nested_d;
         epc_q      <= epc_d;
         irq_prev_q <= irq_s;
      end
   end

   assign pcsrc_req    = take_exc ? CODE_EXC : (take_int ? CODE_INT : 3'd0);
   assign epc_we       = take_exc | take_int;
   // Bypass so the newly saved address is visible in the write cycle itself.
   assign epc          = epc_we ? epc_d : epc_q;
   assign kernel       = (state_q == ST_KERNEL);
   assign irq_pending  = pend_q;
   assign nested_fault = nested_q;

endmodule

// File: tb/tb_exc_irq_ctrl.sv
module tb_exc_irq_ctrl;

   localparam int PC_W = 32;
`ifdef IRQ_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic            clk;
   logic            reset;
   logic            irq_in;
   logic            illop_in;
   logic            instr_valid;
   logic            eret_in;
   logic [PC_W-1:0] pc_cur;
   logic [PC_W-1:0] pc_plus4;
   logic [2:0]      pcsrc_req;
   logic [PC_W-1:0] epc;
   logic            epc_we;
   logic            kernel;
   logic            irq_pending;
   logic            nested_fault;

   exc_irq_ctrl #(.PC_W(PC_W), .CODE_INT(3'd4), .CODE_EXC(3'd5)) dut (
      .clk          (clk),
      .reset        (reset),
      .irq_in       (irq_in),
      .illop_in     (illop_in),
      .instr_valid  (instr_valid),
      .eret_in      (eret_in),
      .pc_cur       (pc_cur),
      .pc_plus4     (pc_plus4),
      .pcsrc_req    (pcsrc_req),
      .epc          (epc),
      .epc_we       (epc_we),
      .kernel       (kernel),
      .irq_pending  (irq_pending),
      .nested_fault (nested_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: mode, pending flag, sticky fault, saved address, and
   // the history of irq_in as seen at each rising clk edge.
   bit              m_kernel;
   bit              m_pend;
   bit              m_nested;
   logic [PC_W-1:0] m_epc;
   bit              samp[$];

   logic [2:0]      obs_req;
   logic [PC_W-1:0] obs_epc;
   logic            obs_we;
   logic            obs_kernel;
   logic            obs_pend;
   logic            obs_nested;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      m_kernel = 0;
      m_pend   = 0;
      m_nested = 0;
      m_epc    = '0;
      samp.delete();
      for (int i = 0; i <= LAT; i++) samp.push_back(1'b0);
   endtask

   // One clock cycle: drive at negedge, check outputs 1 time unit later,
   // then advance the model at the rising edge.
   task automatic cycle(input logic v, input logic ill, input logic er,
                        input logic irq, input logic [PC_W-1:0] pc);
      bit              e_exc, e_int, rise;
      logic [2:0]      e_req;
      logic [PC_W-1:0] e_epc;
      int              n;
      @(negedge clk);
      instr_valid = v;
      illop_in    = ill;
      eret_in     = er;
      irq_in      = irq;
      pc_cur      = pc;
      pc_plus4    = pc + 32'd4;
      #1;
      e_exc = v && !m_kernel && ill;
      e_int = v && !m_kernel && !ill && m_pend;
      e_req = e_exc ? 3'd5 : (e_int ? 3'd4 : 3'd0);
      e_epc = e_exc ? pc + 32'd4 : (e_int ? pc : m_epc);
      obs_req    = pcsrc_req;
      obs_epc    = epc;
      obs_we     = epc_we;
      obs_kernel = kernel;
      obs_pend   = irq_pending;
      obs_nested = nested_fault;
      chk("pcsrc_req",    {29'd0, pcsrc_req}, {29'd0, e_req});
      chk("epc_we",       {31'd0, epc_we}, {31'd0, (e_exc || e_int)});
      chk("epc",          epc, e_epc);
      chk("kernel",       {31'd0, kernel}, {31'd0, m_kernel});
      chk("irq_pending",  {31'd0, irq_pending}, {31'd0, m_pend});
      chk("nested_fault", {31'd0, nested_fault}, {31'd0, m_nested});
      @(posedge clk);
      samp.push_back(irq);
      n    = samp.size() - 1;
      rise = samp[n-LAT+1] && !samp[n-LAT];
      if (samp.size() > 8) void'(samp.pop_front());
      if (v && m_kernel && ill) m_nested = 1;
      if (e_exc || e_int) begin
         m_kernel = 1;
         m_epc    = e_epc;
      end else if (v && m_kernel && er) begin
         m_kernel = 0;
      end
      if (e_int) m_pend = 0;
      if (rise)  m_pend = 1;
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear immediately,
   // even with a would-be exception on the inputs.
   task automatic apply_reset();
      @(negedge clk);
      #2;
      instr_valid = 1'b1;
      illop_in    = 1'b1;
      eret_in     = 1'b0;
      irq_in      = 1'b0;
      reset       = 1'b0;
      #1;
      chk("rst_kernel", {31'd0, kernel}, 32'd0);
      chk("rst_pend",   {31'd0, irq_pending}, 32'd0);
      chk("rst_nested", {31'd0, nested_fault}, 32'd0);
      chk("rst_epc",    epc, 32'd0);
      chk("rst_req",    {29'd0, pcsrc_req}, 32'd0);
      chk("rst_we",     {31'd0, epc_we}, 32'd0);
      model_clear();
      @(negedge clk);
      #2;
      instr_valid = 1'b0;
      illop_in    = 1'b0;
      reset       = 1'b1;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic irq_r;
      reset       = 1'b1;
      irq_in      = 1'b0;
      illop_in    = 1'b0;
      instr_valid = 1'b0;
      eret_in     = 1'b0;
      pc_cur      = '0;
      pc_plus4    = 32'd4;
      model_clear();
      apply_reset();

      // Interrupt taken from user mode
      repeat (LAT) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
      chk("tp1_req", {29'd0, obs_req}, 32'd4);
      chk("tp1_epc", obs_epc, 32'h0000_0040);
      chk("tp1_we",  {31'd0, obs_we}, 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h44);
      chk("tp1_kernel", {31'd0, obs_kernel}, 32'd1);
      chk("tp1_pend",   {31'd0, obs_pend}, 32'd0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h80);

      // Illegal opcode exception
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0100);
      chk("tp2_req", {29'd0, obs_req}, 32'd5);
      chk("tp2_epc", obs_epc, 32'h0000_0104);
      chk("tp2_we",  {31'd0, obs_we}, 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h80);
      chk("tp2_kernel", {31'd0, obs_kernel}, 32'd1);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h84);

      // Exception beats pending interrupt; interrupt follows after return
      repeat (LAT) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
      chk("tp3_req", {29'd0, obs_req}, 32'd5);
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h80);
      chk("tp3_pend_kept", {31'd0, obs_pend}, 32'd1);
      chk("tp3_eret_req",  {29'd0, obs_req}, 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h300);
      chk("tp3_int_req", {29'd0, obs_req}, 32'd4);

      // Kernel: new edge accumulates, nested fault, then return
      repeat (LAT + 1) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h80);
      repeat (LAT) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h84);
      chk("tp4_no_redirect", {29'd0, obs_req}, 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h88);
      chk("tp4_pend",   {31'd0, obs_pend}, 32'd1);
      chk("tp4_nested", {31'd0, obs_nested}, 32'd1);
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h88);
      chk("tp4_eret_req", {29'd0, obs_req}, 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h400);
      chk("tp4_user", {31'd0, obs_kernel}, 32'd0);

      // New edge registered in the same cycle the interrupt is taken
      repeat (LAT + 1) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h400);
      repeat (LAT - 1) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h400);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h400);
      chk("tp5_req", {29'd0, obs_req}, 32'd4);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
      chk("tp5_pend_reset", {31'd0, obs_pend}, 32'd1);
      chk("tp5_kernel",     {31'd0, obs_kernel}, 32'd1);

      // Reset mid-handler with pending interrupt and sticky fault
      apply_reset();

      // Randomized traffic against the model
      irq_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         logic v, ill, er;
         if ($urandom_range(0, 5) == 0) irq_r = ~irq_r;
         v   = ($urandom_range(0, 3) != 0);
         ill = ($urandom_range(0, 7) == 0);
         er  = ($urandom_range(0, 3) == 0);
         cycle(v, ill, er, irq_r, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
         if ($urandom_range(0, 299) == 0) begin
            apply_reset();
            irq_r = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/exc_irq_ctrl.md
Name: exc_irq_ctrl

Overview:
Interrupt/exception controller that issues PC redirect requests to the next-PC selector in the single-cycle CPU. It produces select code 4 (interrupt vector 0x80000004) or code 5 (exception vector 0x80000008), and saves the return address for $26 ($k0). It tracks user/kernel mode and holds one pending timer interrupt. It releases kernel mode on return-from-handler (jr $26 in kernel).

Parameters:
PC_W, 32, width of PC/EPC
CODE_INT, 3'd4, PCSrc code for interrupt redirect
CODE_EXC, 3'd5, PCSrc code for exception redirect

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
irq_in  in  1  level interrupt from timer peripheral (asynchronous to decode)
illop_in  in  1  decoder flags undefined opcode for current instruction
instr_valid  in  1  current instruction commits this cycle
eret_in  in  1  decoder flags jr $26 for current instruction
pc_cur  in  PC_W  PC of current instruction
pc_plus4  in  PC_W  pc_cur+4
pcsrc_req  out  3  0 = no redirect, CODE_INT or CODE_EXC = force vector
epc  out  PC_W  return address to write into $26
epc_we  out  1  write strobe for $26
kernel  out  1  1 while in handler
irq_pending  out  1  latched, untaken interrupt
nested_fault  out  1  sticky: illop while in kernel

Behaviour:
- Reset (reset=0, asynchronous): state=USER, kernel=0, irq_pending=0, nested_fault=0, epc=0. Combinational outputs pcsrc_req=0 and epc_we=0 during reset.
- IRQ path: irq_in is edge-detected. A 0->1 edge sets irq_pending. It stays set until taken. Further edges while pending are merged into the one pending interrupt.
- States: USER and KERNEL. Decisions are Mealy, made in the cycle where instr_valid=1. The state register updates on the rising clk edge.
- In USER with instr_valid=1, decisions in priority order:
  - illop_in=1: exception. pcsrc_req=CODE_EXC, epc=pc_plus4 (faulting instruction skipped), epc_we=1. Next state KERNEL. If irq_pending=1 it is left set.
  - else irq_pending=1: interrupt. pcsrc_req=CODE_INT, epc=pc_cur (current instruction squashed, re-executed on return), epc_we=1. irq_pending is cleared at the edge. Next state KERNEL.
  - else no action, pcsrc_req=0.
- An edge that arrives in the same cycle an interrupt is taken re-sets irq_pending (set wins over clear).
- Every redirect (pcsrc_req!=0) lasts exactly one cycle, and epc_we is asserted in that same cycle only.
- epc is a registered copy of the last saved value; the output shows the new value from the cycle of epc_we onward (mux bypass in that cycle).
- In KERNEL:
  - Interrupts are not taken; irq_pending accumulates.
  - illop_in with instr_valid sets nested_fault. There is no redirect and no epc write.
  - eret_in with instr_valid returns to USER at the edge.
  - A pending interrupt is taken no earlier than the first USER instruction after return; there is no back-to-back redirect in the eret cycle.
- instr_valid=0: no state change and no redirect. Edge detection still runs.
- kernel=1 exactly when state=KERNEL.
- nested_fault is cleared only by reset.
- Reset mid-handler: returns to USER and drops any pending interrupt.

Optional Feature:
IRQ_SYNC_EN:
- Defined: irq_in passes through a 2-flop synchronizer before the edge-detect flop. Pending is set 3 clk edges after irq_in rises.
- Undefined: a single edge-detect flop samples irq_in directly. Pending is set at the first edge after irq_in rises.
- Reset values of all synchronizer flops are 0.

Test Plan:
- Reset, then irq_in=1 with USER, instr_valid=1, pc_cur=0x00000040 -> irq_pending=1 after sync latency. The next valid cycle gives pcsrc_req=4, epc=0x00000040, epc_we=1; the following cycle gives kernel=1, irq_pending=0.
- USER, illop_in=1, pc_plus4=0x00000104 -> pcsrc_req=5, epc=0x00000104, epc_we=1, kernel=1 after edge.
- illop_in=1 and irq_pending=1 in the same cycle -> pcsrc_req=5. irq_pending stays 1; after eret, the next USER valid instruction gives pcsrc_req=4.
- KERNEL: raise a new irq edge and pulse illop_in -> no redirect, irq_pending=1, nested_fault=1. eret_in=1 -> kernel=0 next cycle with pcsrc_req=0 in the eret cycle.
- irq edge arriving in the same cycle an interrupt is taken -> irq_pending=1 after the edge.
- reset deasserted→asserted while kernel=1 and irq_pending=1 -> immediately kernel=0, irq_pending=0, epc=0, nested_fault=0.
